// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
//  Shared types and constants for the unified-memory port arbiter.
//  Contents:
//    arb_state_t  - arbiter FSM encoding (IDLE / BUSY_IF / BUSY_DM)
//    OWNER_IF/DM  - requester identifiers
//    ADDR_W_DEF / DATA_W_DEF - default bus widths
//    busy_state() - maps a requester to its BUSY state
// -----------------------------------------------------------------------------
package pipeline_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_t;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_DM = 1'b1;

  function automatic arb_state_t busy_state(input logic owner);
    return (owner == OWNER_DM) ? BUSY_DM : BUSY_IF;
  endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// -----------------------------------------------------------------------------
// mem_arb_starve_ctr
//  Counts consecutive DM grants that were won while IF was also requesting.
//  Once the count reaches MAX_WAIT, force_if_o tells the arbiter to hand the
//  next contested slot to IF. Any IF grant clears the count.
//  Used by mem_port_arbiter only when MEM_ARB_STARVE_GUARD_EN is defined.
//  Ports:
//    clk_i, reset_i  - clock, synchronous active-high reset
//    if_req_i        - IF currently requesting
//    if_gnt_i        - IF granted this cycle
//    dm_gnt_i        - DM granted this cycle
//    force_if_o      - counter has reached MAX_WAIT
// -----------------------------------------------------------------------------
module mem_arb_starve_ctr
  import pipeline_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic if_req_i,
  input  logic if_gnt_i,
  input  logic dm_gnt_i,
  output logic force_if_o
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (if_gnt_i) begin
      cnt_d = '0;
    end else if (dm_gnt_i && if_req_i && (cnt_q != MAX_CNT)) begin
      // Saturate: a contested DM grant at MAX_CNT cannot happen, but keep
      // the counter from wrapping regardless.
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_if_o = (cnt_q == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//  Shares one single-ported unified memory between instruction fetch (IF) and
//  data access (DM). One requester is granted at a time (combinationally, from
//  IDLE); its request is registered and held on the memory port until
//  mem_ack_i, and the completion (rvalid + registered read data) is returned
//  on the following cycle, which is again IDLE and may grant immediately.
//  DM wins contested arbitration by default.
//
//  Optional feature macro: MEM_ARB_STARVE_GUARD_EN
//    Defined   - after MAX_WAIT consecutive contested DM grants, the next
//                contested arbitration goes to IF (mem_arb_starve_ctr).
//    Undefined - strict DM priority.
//
//  Ports:
//    clk_i, reset_i                     clock, synchronous active-high reset
//    if_req_i/if_addr_i                 IF read request
//    if_gnt_o/if_rvalid_o/if_rdata_o    IF grant, completion pulse, data
//    if_stall_o                         if_req_i & ~if_rvalid_o
//    dm_req_i/dm_we_i/dm_be_i/
//      dm_addr_i/dm_wdata_i             DM load/store request
//    dm_gnt_o/dm_rvalid_o/dm_rdata_o    DM grant, completion pulse, load data
//    dm_stall_o                         dm_req_i & ~dm_rvalid_o
//    mem_req_o/mem_we_o/mem_be_o/
//      mem_addr_o/mem_wdata_o           registered memory request
//    mem_ack_i/mem_rdata_i              memory completion and read data
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import pipeline_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk_i,
  input  logic                reset_i,
  // instruction fetch
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_stall_o,
  // data access
  input  logic                dm_req_i,
  input  logic                dm_we_i,
  input  logic [DATA_W/8-1:0] dm_be_i,
  input  logic [ADDR_W-1:0]   dm_addr_i,
  input  logic [DATA_W-1:0]   dm_wdata_i,
  output logic                dm_gnt_o,
  output logic                dm_rvalid_o,
  output logic [DATA_W-1:0]   dm_rdata_o,
  output logic                dm_stall_o,
  // memory
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_ack_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t          state_q, state_d;
  logic                mem_we_q, mem_we_d;
  logic [BE_W-1:0]     mem_be_q, mem_be_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic                dm_rvalid_q, dm_rvalid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                if_gnt, dm_gnt;
  logic                force_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
  mem_arb_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_ctr (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .if_req_i   (if_req_i),
    .if_gnt_i   (if_gnt),
    .dm_gnt_i   (dm_gnt),
    .force_if_o (force_if)
  );
`else
  // Strict DM priority; MAX_WAIT has no effect (the expression is constant 0
  // for any legal MAX_WAIT).
  assign force_if = (MAX_WAIT < 0);
`endif

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_gnt      = 1'b0;
    dm_gnt      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A grant during reset would be discarded by the reset edge, so
        // don't advertise one to the requester.
        if (!reset_i) begin
          dm_gnt = dm_req_i & ~(if_req_i & force_if);
          if_gnt = if_req_i & ~dm_gnt;
        end
        if (dm_gnt) begin
          state_d     = busy_state(OWNER_DM);
          mem_we_d    = dm_we_i;
          mem_be_d    = dm_be_i;
          mem_addr_d  = dm_addr_i;
          mem_wdata_d = dm_wdata_i;
        end else if (if_gnt) begin
          // Instruction fetch is always a full-word read.
          state_d     = busy_state(OWNER_IF);
          mem_we_d    = 1'b0;
          mem_be_d    = '1;
          mem_addr_d  = if_addr_i;
          mem_wdata_d = '0;
        end
      end
      BUSY_IF: begin
        if (mem_ack_i) begin
          state_d     = IDLE;
          if_rvalid_d = 1'b1;
          if_rdata_d  = mem_rdata_i;
        end
      end
      BUSY_DM: begin
        if (mem_ack_i) begin
          state_d     = IDLE;
          dm_rvalid_d = 1'b1;
          // Stores complete with a pulse but keep the last load data.
          if (!mem_we_q) begin
            dm_rdata_d = mem_rdata_i;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign if_gnt_o    = if_gnt;
  assign dm_gnt_o    = dm_gnt;
  assign if_rvalid_o = if_rvalid_q;
  assign dm_rvalid_o = dm_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign if_stall_o  = if_req_i & ~if_rvalid_q;
  assign dm_stall_o  = dm_req_i & ~dm_rvalid_q;

  assign mem_req_o   = (state_q != IDLE);
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//  Directed stimulus with a transaction-level reference model: the model keeps
//  "who owns the memory" and the captured request, and a compare process checks
//  every DUT output against it on each falling edge. Hand-computed literal
//  checks in the stimulus pin the model. Honours MEM_ARB_STARVE_GUARD_EN.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int BE_W     = DATA_W / 8;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt_o, if_rvalid_o, if_stall_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              dm_req, dm_we;
  logic [BE_W-1:0]   dm_be;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt_o, dm_rvalid_o, dm_stall_o;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              mem_req_o, mem_we_o;
  logic [BE_W-1:0]   mem_be_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  mem_port_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk_i       (clk),
    .reset_i     (rst),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_gnt_o    (if_gnt_o),
    .if_rvalid_o (if_rvalid_o),
    .if_rdata_o  (if_rdata_o),
    .if_stall_o  (if_stall_o),
    .dm_req_i    (dm_req),
    .dm_we_i     (dm_we),
    .dm_be_i     (dm_be),
    .dm_addr_i   (dm_addr),
    .dm_wdata_i  (dm_wdata),
    .dm_gnt_o    (dm_gnt_o),
    .dm_rvalid_o (dm_rvalid_o),
    .dm_rdata_o  (dm_rdata_o),
    .dm_stall_o  (dm_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_be_o    (mem_be_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack),
    .mem_rdata_i (mem_rdata)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // m_owner: 0 = memory free, 1 = IF transaction outstanding, 2 = DM outstanding
  int              m_owner   = 0;
  bit              m_if_rv   = 1'b0;
  bit              m_dm_rv   = 1'b0;
  logic [31:0]     m_if_rdata = '0;
  logic [31:0]     m_dm_rdata = '0;
  logic            m_we      = 1'b0;
  logic [BE_W-1:0] m_be      = '0;
  logic [31:0]     m_addr    = '0;
  logic [31:0]     m_wdata   = '0;
  int              m_starve  = 0;

  function automatic bit guard_forces_if();
`ifdef MEM_ARB_STARVE_GUARD_EN
    return (m_starve >= MAX_WAIT);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_dm_gnt();
    return !rst && (m_owner == 0) && dm_req && !(if_req && guard_forces_if());
  endfunction

  function automatic bit exp_if_gnt();
    return !rst && (m_owner == 0) && if_req && !exp_dm_gnt();
  endfunction

  always @(posedge clk) begin
    bit g_dm, g_if;
    g_dm = exp_dm_gnt();
    g_if = exp_if_gnt();
    cyc++;
    if (rst) begin
      m_owner = 0; m_if_rv = 0; m_dm_rv = 0; m_if_rdata = '0; m_dm_rdata = '0;
      m_we = 0; m_be = '0; m_addr = '0; m_wdata = '0; m_starve = 0;
    end else begin
      m_if_rv = 0;
      m_dm_rv = 0;
      if (m_owner != 0) begin
        if (mem_ack) begin
          if (m_owner == 1) begin
            m_if_rv = 1; m_if_rdata = mem_rdata;
          end else begin
            m_dm_rv = 1;
            if (!m_we) m_dm_rdata = mem_rdata;
          end
          m_owner = 0;
        end
      end else if (g_dm) begin
        m_owner = 2; m_we = dm_we; m_be = dm_be; m_addr = dm_addr; m_wdata = dm_wdata;
        if (if_req) m_starve++;
      end else if (g_if) begin
        m_owner = 1; m_we = 0; m_be = '1; m_addr = if_addr; m_wdata = '0;
        m_starve = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("if_gnt",    if_gnt_o,    exp_if_gnt());
      chk("dm_gnt",    dm_gnt_o,    exp_dm_gnt());
      chk("if_rvalid", if_rvalid_o, m_if_rv);
      chk("dm_rvalid", dm_rvalid_o, m_dm_rv);
      chk("if_rdata",  if_rdata_o,  m_if_rdata);
      chk("dm_rdata",  dm_rdata_o,  m_dm_rdata);
      chk("if_stall",  if_stall_o,  if_req & ~m_if_rv);
      chk("dm_stall",  dm_stall_o,  dm_req & ~m_dm_rv);
      chk("mem_req",   mem_req_o,   m_owner != 0);
      if (m_owner != 0) begin
        chk("mem_we",    mem_we_o,    m_we);
        chk("mem_be",    mem_be_o,    m_be);
        chk("mem_addr",  mem_addr_o,  m_addr);
        chk("mem_wdata", mem_wdata_o, m_wdata);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold IF requesting while DM requests continuously; count DM grants seen
  // before IF wins. Memory acks every busy cycle immediately.
  task automatic contend_round(output int dm_cnt, output bit if_won);
    dm_cnt = 0;
    if_won = 1'b0;
    if_req = 1'b1;
    if_addr = 32'h600;
    for (int k = 0; k < 40 && !if_won; k++) begin
      @(negedge clk);
      if (if_gnt_o) if_won = 1'b1;
      else if (dm_gnt_o) dm_cnt++;
      tick();
      mem_ack   = mem_req_o;
      mem_rdata = 32'h1000 + k;
      if (if_won) if_req = 1'b0;
    end
    if_req = 1'b0;
  endtask

  initial begin
    int  dm_cnt;
    bit  if_won;

    rst = 1'b1; if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_be = '0;
    dm_addr = '0; dm_wdata = '0; mem_ack = 0; mem_rdata = '0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_dm_rvalid", dm_rvalid_o, 0);
    chk("rst_if_rdata", if_rdata_o, 0);

    // IF-only read, ack in the first busy cycle
    tick(); if_req = 1; if_addr = 32'h100;
    @(negedge clk); chk("t2_if_gnt", if_gnt_o, 1);
    tick(); if_req = 0; mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk); chk("t2_mem_req", mem_req_o, 1); chk("t2_mem_addr", mem_addr_o, 32'h100);
    tick(); mem_ack = 0;
    @(negedge clk); chk("t2_if_rvalid", if_rvalid_o, 1); chk("t2_if_rdata", if_rdata_o, 32'hDEADBEEF);
    tick();
    @(negedge clk); chk("t2_if_rvalid_off", if_rvalid_o, 0); chk("t2_if_rdata_hold", if_rdata_o, 32'hDEADBEEF);

    // Contention: DM store first, IF granted in the DM completion cycle
    tick(); if_req = 1; if_addr = 32'h200;
    dm_req = 1; dm_we = 1; dm_be = 4'b0011; dm_addr = 32'h300; dm_wdata = 32'h1234;
    @(negedge clk); chk("t3_dm_gnt", dm_gnt_o, 1); chk("t3_if_gnt", if_gnt_o, 0);
    tick(); dm_req = 0; mem_ack = 1; mem_rdata = 32'hBAD0BAD0;
    @(negedge clk); chk("t3_mem_we", mem_we_o, 1); chk("t3_mem_be", mem_be_o, 4'b0011);
    chk("t3_mem_wdata", mem_wdata_o, 32'h1234);
    tick(); mem_ack = 0;
    @(negedge clk); chk("t3_dm_rvalid", dm_rvalid_o, 1); chk("t3_if_gnt2", if_gnt_o, 1);
    chk("t3_dm_rdata_kept", dm_rdata_o, 0);
    tick(); if_req = 0; mem_ack = 1; mem_rdata = 32'hCAFE0001;
    @(negedge clk); chk("t3_if_addr", mem_addr_o, 32'h200);
    tick(); mem_ack = 0;
    @(negedge clk); chk("t3_if_rdata", if_rdata_o, 32'hCAFE0001);

    // Wait states: ack arrives in the 4th busy cycle
    tick(); dm_req = 1; dm_we = 0; dm_be = 4'hF; dm_addr = 32'h400; dm_wdata = '0;
    @(negedge clk); chk("t4_dm_gnt", dm_gnt_o, 1);
    tick(); dm_req = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin mem_ack = 1; mem_rdata = 32'h55AA55AA; end
      @(negedge clk); chk("t4_mem_req_held", mem_req_o, 1); chk("t4_mem_addr_held", mem_addr_o, 32'h400);
      chk("t4_no_early_rvalid", dm_rvalid_o, 0);
      tick();
    end
    mem_ack = 0;
    @(negedge clk); chk("t4_dm_rvalid", dm_rvalid_o, 1); chk("t4_dm_rdata", dm_rdata_o, 32'h55AA55AA);
    tick();
    @(negedge clk); chk("t4_single_pulse", dm_rvalid_o, 0); chk("t4_mem_req_off", mem_req_o, 0);

    // Spurious ack in IDLE
    tick(); mem_ack = 1; mem_rdata = 32'h0BADF00D;
    @(negedge clk); chk("t5_mem_req", mem_req_o, 0);
    tick(); mem_ack = 0;
    @(negedge clk); chk("t5_dm_rvalid", dm_rvalid_o, 0); chk("t5_if_rvalid", if_rvalid_o, 0);
    chk("t5_dm_rdata", dm_rdata_o, 32'h55AA55AA);

    // Starvation guard
    tick(); dm_req = 1; dm_we = 0; dm_be = 4'hF; dm_addr = 32'h500;
    contend_round(dm_cnt, if_won);
`ifdef MEM_ARB_STARVE_GUARD_EN
    chk("t6_dm_grants", dm_cnt, MAX_WAIT);
    chk("t6_if_won", if_won, 1);
    // Let a few uncontested DM grants pass, then contend again: counter was cleared.
    repeat (4) begin tick(); mem_ack = mem_req_o; end
    contend_round(dm_cnt, if_won);
    chk("t6_dm_grants_after_clear", dm_cnt, MAX_WAIT);
    chk("t6_if_won2", if_won, 1);
`else
    chk("t6_if_never", if_won, 0);
    chk("t6_dm_many", dm_cnt >= 15, 1);
`endif
    dm_req = 0;
    repeat (4) begin tick(); mem_ack = mem_req_o; end
    mem_ack = 0;
    tick();
    @(negedge clk); chk("t6_drained", mem_req_o, 0);

    // Reset during BUSY_DM with a same-cycle ack
    tick(); dm_req = 1; dm_we = 0; dm_be = 4'hF; dm_addr = 32'h700;
    @(negedge clk); chk("t1_dm_gnt", dm_gnt_o, 1);
    tick(); dm_req = 0; mem_ack = 1; mem_rdata = 32'h77777777; rst = 1;
    @(negedge clk); chk("t1_busy", mem_req_o, 1);
    tick(); rst = 0; mem_ack = 0;
    @(negedge clk);
    chk("t1_no_rvalid", dm_rvalid_o, 0); chk("t1_mem_req", mem_req_o, 0);
    chk("t1_dm_rdata", dm_rdata_o, 0); chk("t1_if_rdata", if_rdata_o, 0);
    chk("t1_mem_addr", mem_addr_o, 0); chk("t1_mem_be", mem_be_o, 0);
    chk("t1_mem_we", mem_we_o, 0); chk("t1_mem_wdata", mem_wdata_o, 0);
    tick();
    @(negedge clk); chk("t1_no_late_rvalid", dm_rvalid_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
